running_light_ctrl: RTL and testbench
=====================================

# running_light_ctrl

Sequencer for the board's running-light LED bank. An internal prescaler produces a one-cycle advance tick every `TICK_MAX+1` clocks. On each tick an FSM steps an LED pattern according to a selectable mode. Sits between the debounced key inputs and the LED pins, and replaces free-running per-LED toggle counters with one shared, controlled timebase.

## Interface
- `LED_NUM`, default 4: width of the LED bank; legal range ≥ 2.
- `TICK_MAX`, default 25'd24_999_999: prescaler terminal count; tick period is `TICK_MAX+1` clocks (0.5 s at 50 MHz).
- `sys_clk`, in, 1: system clock.
- `sys_rst_n`, in, 1: asynchronous, active-low reset.
- `key_mode`, in, 1: debounced single-cycle pulse; advances the mode.
- `key_pause`, in, 1: debounced single-cycle pulse; toggles run/pause.
- `led_out`, out, `LED_NUM`: LED drive; 1 = on.
- `tick`, out, 1: registered one-cycle advance pulse.
- `mode`, out, 2: current mode.
- `paused`, out, 1: high while in the PAUSE state.

## Operation
**Modes** (2-bit, increments on each `key_mode` pulse, wraps 3→0):
- 0 SHL: reload `0…01`; rotate left on each tick; MSB wraps to bit 0.
- 1 SHR: reload `10…0`; rotate right on each tick; bit 0 wraps to MSB.
- 2 PING: reload `0…01` with direction = left; single hot bit.
  - Direction flips to right on the tick that lands on the MSB.
  - Direction flips to left on the tick that lands on bit 0.
  - Sequence for `LED_NUM=4`: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
- 3 BLINK: reload all-ones; invert the pattern on each tick.

**FSM** (states RUN, PAUSE):
- RUN, `key_pause` → PAUSE.
- PAUSE, `key_pause` → RUN.
- In PAUSE the prescaler count and pattern hold, and `tick` stays low.

**Mode change:**
- Reloads the new mode's pattern, clears the prescaler, and sets direction to left.
- Allowed in either FSM state; the FSM state is not altered.

**Simultaneous events:**
- `key_mode` and `key_pause` in the same cycle: both apply (reload and state toggle).
- `key_mode` in the same cycle as a prescaler terminal count: the reload wins, no step occurs, and `tick` is suppressed.

**Prescaler** (`cnt`, 25 bits, unsigned):
- Counts 0..`TICK_MAX` and then returns to 0.
- A terminal count in RUN asserts `tick` for one cycle.

## Timing
**Reset values:**
- `led_out` = `0…01`, `mode` = 0, `paused` = 0, `tick` = 0.
- `cnt` = 0, state = RUN, direction = left.

**Latency:**
- `tick` is high in the cycle after `cnt == TICK_MAX`.
- `led_out` shows the stepped pattern in the same cycle `tick` is high; the pattern and `tick` are registered together.
- First tick after reset: `tick` rises on clock edge `TICK_MAX+1` after reset release.
- Key response: `mode`, `paused` and the `led_out` reload are visible one clock after the key pulse.

**Reset mid-operation:** all registers return to their reset values immediately (asynchronous).

**Resume from PAUSE:** counting continues from the held `cnt`; no tick is lost or duplicated.

## Configuration
- `RUNNING_LIGHT_SPEED_EN` defined:
  - Adds input `speed[1:0]`.
  - Tick period becomes `(TICK_MAX+1) << speed`, giving ×1, ×2, ×4 or ×8.
  - The prescaler is widened by 3 bits.
  - A `speed` change clears the prescaler in the next cycle.
- `RUNNING_LIGHT_SPEED_EN` not defined: no `speed` port; fixed period of `TICK_MAX+1`.

## Structure
- `running_light_pkg`:
  - Mode encodings `MODE_SHL`, `MODE_SHR`, `MODE_PING`, `MODE_BLINK`.
  - FSM state encodings `ST_RUN`, `ST_PAUSE`.
  - Direction constants.
- Sub-module `led_tick_gen`:
  - Contains the prescaler with `enable`, `clear` and `tick` ports.
  - Holds the speed-scaling logic under the macro.
  - The FSM and pattern logic stay in the top module.

## Test plan
- Reset, `TICK_MAX=3`, `LED_NUM=4`, mode 0 → `tick` every 4 clocks; `led_out` steps 0001, 0010, 0100, 1000, 0001.
- Two `key_mode` pulses → `mode`=2, `led_out`=0001; ping-pong sequence 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- `key_pause` when `cnt`=2 → `paused`=1 and `led_out` frozen for 20 clocks; a second `key_pause` → next tick arrives exactly 2 clocks later.
- Mode 3 → `led_out`=1111; then 0000, 1111 on successive ticks. Next `key_mode` → mode 0, `led_out`=0001.
- `key_mode` and `key_pause` together at `cnt==TICK_MAX` → no tick; `mode` increments; pattern reloads; `paused`=1.
- Assert `sys_rst_n` low mid-sequence, asynchronous to the clock → all outputs at reset values before the next edge. With `RUNNING_LIGHT_SPEED_EN` and `speed`=2 → tick period 16 clocks.

Source files
------------

// File: rtl/running_light_pkg.sv
// Shared encodings for the running-light LED sequencer: modes, FSM states,
// shift direction and prescaler widths.
package running_light_pkg;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Base prescaler width, and the extra bits needed for the x8 slow-down.
    localparam int CNT_W         = 25;
    localparam int SPEED_EXTRA_W = 3;

    // Modes advance 0..3 and wrap back to SHL.
    function automatic mode_e next_mode(mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shared prescaler: one registered tick every TICK_MAX+1 enabled clocks.
// With RUNNING_LIGHT_SPEED_EN defined, the period is scaled by 1 << speed_i.
module led_tick_gen
    import running_light_pkg::*;
#(
    parameter logic [CNT_W-1:0] TICK_MAX = 25'd24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       enable_i,
    input  logic       clear_i,
`ifdef RUNNING_LIGHT_SPEED_EN
    input  logic [1:0] speed_i,
`endif
    output logic       step_o,
    output logic       tick_o
);

`ifdef RUNNING_LIGHT_SPEED_EN
    localparam int CW = CNT_W + SPEED_EXTRA_W;
`else
    localparam int CW = CNT_W;
`endif

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] limit;
    logic          clear_all;
    logic          at_limit;
    logic          tick_q;

`ifdef RUNNING_LIGHT_SPEED_EN
    logic [1:0] speed_q;

    // A new speed restarts the period so the first scaled tick is a full one.
    assign limit     = ((CW'(TICK_MAX) + CW'(1)) << speed_i) - CW'(1);
    assign clear_all = clear_i | (speed_i != speed_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_q <= 2'd0;
        end else begin
            speed_q <= speed_i;
        end
    end
`else
    assign limit     = CW'(TICK_MAX);
    assign clear_all = clear_i;
`endif

    assign at_limit = (cnt_q == limit);

    // A clear in the terminal cycle swallows the step: the reload wins.
    assign step_o = enable_i & ~clear_all & at_limit;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_all) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = at_limit ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= step_o;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/running_light_ctrl.sv
// Running-light LED sequencer: RUN/PAUSE FSM plus mode-driven pattern stepping
// on a shared prescaler tick. RUNNING_LIGHT_SPEED_EN adds the speed[1:0] input.
module running_light_ctrl
    import running_light_pkg::*;
#(
    parameter int               LED_NUM  = 4,
    parameter logic [CNT_W-1:0] TICK_MAX = 25'd24_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               key_mode,
    input  logic               key_pause,
`ifdef RUNNING_LIGHT_SPEED_EN
    input  logic [1:0]         speed,
`endif
    output logic [LED_NUM-1:0] led_out,
    output logic               tick,
    output logic [1:0]         mode,
    output logic               paused
);

    state_e             state_q;
    state_e             state_d;
    mode_e              mode_q;
    mode_e              mode_d;
    dir_e               dir_q;
    dir_e               dir_d;
    logic [LED_NUM-1:0] led_q;
    logic [LED_NUM-1:0] led_d;
    logic               run_en;
    logic               step;

    function automatic logic [LED_NUM-1:0] reload_pattern(mode_e m);
        case (m)
            MODE_SHR:   return {1'b1, {(LED_NUM-1){1'b0}}};
            MODE_BLINK: return {LED_NUM{1'b1}};
            default:    return {{(LED_NUM-1){1'b0}}, 1'b1};
        endcase
    endfunction

    led_tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable_i  (run_en),
        .clear_i   (key_mode),
`ifdef RUNNING_LIGHT_SPEED_EN
        .speed_i   (speed),
`endif
        .step_o    (step),
        .tick_o    (tick)
    );

    // FSM: state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (key_pause) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    // FSM: outputs. The prescaler follows the upcoming state, so a pause pulse
    // freezes the count at once and no tick ever coincides with paused=1.
    always_comb begin
        paused = (state_q == ST_PAUSE);
        run_en = (state_d == ST_RUN);
    end

    // Pattern, mode and direction next-state
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        if (key_mode) begin
            mode_d = next_mode(mode_q);
            dir_d  = DIR_LEFT;
            led_d  = reload_pattern(mode_d);
        end else if (step) begin
            case (mode_q)
                MODE_SHL: led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                MODE_SHR: led_d = {led_q[0], led_q[LED_NUM-1:1]};
                MODE_PING: begin
                    // Direction turns on the tick that lands on an end bit.
                    if (dir_q == DIR_LEFT) begin
                        led_d = led_q << 1;
                        if (led_d[LED_NUM-1]) dir_d = DIR_RIGHT;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_d[0]) dir_d = DIR_LEFT;
                    end
                end
                default:  led_d = ~led_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_SHL;
            dir_q  <= DIR_LEFT;
            led_q  <= {{(LED_NUM-1){1'b0}}, 1'b1};
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
        end
    end

    assign led_out = led_q;
    assign mode    = mode_q;

endmodule

// File: tb/tb_running_light_ctrl.sv
// Directed bench for running_light_ctrl with LED_NUM=4, TICK_MAX=3.
// Covers the speed scaling when RUNNING_LIGHT_SPEED_EN is defined.
module tb_running_light_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_mode  = 1'b0;
    logic       key_pause = 1'b0;
`ifdef RUNNING_LIGHT_SPEED_EN
    logic [1:0] speed     = 2'd0;
`endif
    logic [3:0] led_out;
    logic       tick;
    logic [1:0] mode;
    logic       paused;

    int checks = 0;
    int errors = 0;

    running_light_ctrl #(
        .LED_NUM  (4),
        .TICK_MAX (25'd3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_mode  (key_mode),
        .key_pause (key_pause),
`ifdef RUNNING_LIGHT_SPEED_EN
        .speed     (speed),
`endif
        .led_out   (led_out),
        .tick      (tick),
        .mode      (mode),
        .paused    (paused)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++; if (led_out !== 4'b0001) begin errors++; $display("FAIL reset_led got %b want 0001", led_out); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %b want 0", paused); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        sys_rst_n = 1'b1;
    endtask

    // First tick lands on edge 4 after release, then every 4 clocks.
    task automatic test_shl();
        logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 1; k <= 16; k++) begin
            @(negedge sys_clk);
            checks++;
            if (tick !== (k % 4 == 0)) begin
                errors++; $display("FAIL shl_tick clk %0d got %b want %b", k, tick, (k % 4 == 0));
            end
            if (k % 4 == 0) begin
                checks++;
                if (led_out !== seq[k/4-1]) begin
                    errors++; $display("FAIL shl_led step %0d got %b want %b", k / 4, led_out, seq[k/4-1]);
                end
            end
        end
    endtask

    task automatic test_ping();
        logic [3:0] seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        key_mode = 1'b1;
        @(negedge sys_clk);
        checks++; if (mode !== 2'd1 || led_out !== 4'b1000) begin
            errors++; $display("FAIL shr_reload mode %0d led %b want mode 1 led 1000", mode, led_out);
        end
        @(negedge sys_clk);
        key_mode = 1'b0;
        checks++; if (mode !== 2'd2 || led_out !== 4'b0001 || tick !== 1'b0) begin
            errors++; $display("FAIL ping_reload mode %0d led %b tick %b want 2 0001 0", mode, led_out, tick);
        end
        for (int k = 1; k <= 28; k++) begin
            @(negedge sys_clk);
            checks++;
            if (tick !== (k % 4 == 0)) begin
                errors++; $display("FAIL ping_tick clk %0d got %b", k, tick);
            end
            if (k % 4 == 0) begin
                checks++;
                if (led_out !== seq[k/4-1]) begin
                    errors++; $display("FAIL ping_led step %0d got %b want %b", k / 4, led_out, seq[k/4-1]);
                end
            end
        end
    endtask

    // Pause with the prescaler at 2; on resume two clocks remain to the tick.
    task automatic test_pause();
        repeat (2) @(negedge sys_clk);
        key_pause = 1'b1;
        @(negedge sys_clk);
        key_pause = 1'b0;
        checks++; if (paused !== 1'b1 || tick !== 1'b0) begin
            errors++; $display("FAIL pause_enter paused %b tick %b want 1 0", paused, tick);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            checks++;
            if (tick !== 1'b0 || led_out !== 4'b0010 || paused !== 1'b1) begin
                errors++; $display("FAIL pause_hold clk %0d tick %b led %b paused %b want 0 0010 1", k, tick, led_out, paused);
            end
        end
        key_pause = 1'b1;
        @(negedge sys_clk);
        key_pause = 1'b0;
        checks++; if (paused !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL resume paused %b tick %b want 0 0", paused, tick);
        end
        @(negedge sys_clk);
        checks++; if (tick !== 1'b1 || led_out !== 4'b0100) begin
            errors++; $display("FAIL resume_tick tick %b led %b want 1 0100", tick, led_out);
        end
    endtask

    task automatic test_blink();
        key_mode = 1'b1;
        @(negedge sys_clk);
        key_mode = 1'b0;
        checks++; if (mode !== 2'd3 || led_out !== 4'b1111 || tick !== 1'b0) begin
            errors++; $display("FAIL blink_reload mode %0d led %b tick %b want 3 1111 0", mode, led_out, tick);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            if (k % 4 == 0) begin
                checks++;
                if (tick !== 1'b1 || led_out !== ((k == 4) ? 4'b0000 : 4'b1111)) begin
                    errors++; $display("FAIL blink_step %0d tick %b led %b", k / 4, tick, led_out);
                end
            end
        end
        key_mode = 1'b1;
        @(negedge sys_clk);
        key_mode = 1'b0;
        checks++; if (mode !== 2'd0 || led_out !== 4'b0001) begin
            errors++; $display("FAIL mode_wrap mode %0d led %b want 0 0001", mode, led_out);
        end
    endtask

    // Both keys in the terminal-count cycle: reload wins, state toggles.
    task automatic test_simultaneous();
        repeat (3) @(negedge sys_clk);
        key_mode  = 1'b1;
        key_pause = 1'b1;
        @(negedge sys_clk);
        key_mode  = 1'b0;
        key_pause = 1'b0;
        checks++; if (tick !== 1'b0 || mode !== 2'd1 || led_out !== 4'b1000 || paused !== 1'b1) begin
            errors++; $display("FAIL simul tick %b mode %0d led %b paused %b want 0 1 1000 1", tick, mode, led_out, paused);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            checks++;
            if (tick !== 1'b0 || led_out !== 4'b1000) begin
                errors++; $display("FAIL simul_hold clk %0d tick %b led %b", k, tick, led_out);
            end
        end
        key_pause = 1'b1;
        @(negedge sys_clk);
        key_pause = 1'b0;
        checks++; if (paused !== 1'b0) begin
            errors++; $display("FAIL simul_resume paused %b want 0", paused);
        end
    endtask

    task automatic test_async_reset();
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if (led_out !== 4'b0001 || mode !== 2'd0 || paused !== 1'b0 || tick !== 1'b0) begin
            errors++; $display("FAIL async_reset led %b mode %0d paused %b tick %b want 0001 0 0 0", led_out, mode, paused, tick);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Measures the interval between two consecutive ticks.
    task automatic test_period();
        int shift = 0;
        int n;
`ifdef RUNNING_LIGHT_SPEED_EN
        speed = 2'd2;
        shift = 2;
`endif
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (tick !== 1'b1 && n < 200);
        checks++; if (tick !== 1'b1) begin
            errors++; $display("FAIL period_first_tick timeout after %0d clocks", n);
        end
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (tick !== 1'b1 && n < 200);
        checks++; if (n !== (4 << shift)) begin
            errors++; $display("FAIL period got %0d want %0d", n, 4 << shift);
        end
    endtask

    initial begin
        test_reset();
        test_shl();
        test_ping();
        test_pause();
        test_blink();
        test_simultaneous();
        test_async_reset();
        test_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
